// File: rtl/jpeg_rle_pkg.sv
// Shared definitions for the run-length expander and its page-boundary stream register.
package jpeg_rle_pkg;

  localparam int unsigned BLOCK_LEN = 64;
  localparam int unsigned LEVEL_W   = 12;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned TOKEN_W   = 16;
  localparam int unsigned RUN_W     = 4;
  localparam int unsigned POS_W     = $clog2(BLOCK_LEN);

  localparam int unsigned RUN_MSB   = 15;
  localparam int unsigned RUN_LSB   = 12;
  localparam int unsigned LEVEL_MSB = 11;
  localparam int unsigned LEVEL_LSB = 0;

  localparam logic [TOKEN_W-1:0] EOB_CODE = 16'h0000;
  localparam logic [TOKEN_W-1:0] ZRL_CODE = 16'hF000;

  typedef enum logic [1:0] {
    ST_GET    = 2'd0,
    ST_ZEROS  = 2'd1,
    ST_FILL   = 2'd2,
    ST_EOSOUT = 2'd3
  } state_t;

  function automatic logic [COEF_W-1:0] sext_level(input logic [LEVEL_W-1:0] lvl);
    return {{(COEF_W-LEVEL_W){lvl[LEVEL_W-1]}}, lvl};
  endfunction

endpackage

// File: rtl/jpeg_stream_reg.sv
// d/e/v output register for a valid/back-pressure stream; loads when empty or draining.
module jpeg_stream_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  input  logic         i_e,
  input  logic         i_b,
  output logic [W-1:0] o_d,
  output logic         o_e,
  output logic         o_v,
  output logic         o_load_ok
);

  logic [W-1:0] r_d;
  logic         r_e;
  logic         r_v;

  assign o_load_ok = ~r_v | ~i_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_d <= '0;
      r_e <= 1'b0;
      r_v <= 1'b0;
    end else if (o_load_ok) begin
      r_v <= i_ld;
      if (i_ld) begin
        r_d <= i_d;
        r_e <= i_e;
      end
    end
  end

  assign o_d = r_d;
  assign o_e = r_e;
  assign o_v = r_v;

endmodule

// File: rtl/jpeg_rle_expand.sv
// Expands (run, level) tokens into 64 zigzag-order coefficients per block, with EOB/ZRL,
// end-of-stream and overrun handling.
module jpeg_rle_expand
  import jpeg_rle_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [TOKEN_W-1:0] rlS_d,
  input  logic               rlS_e,
  input  logic               rlS_v,
  output logic               rlS_b,
  output logic [COEF_W-1:0]  ruS_d,
  output logic               ruS_e,
  output logic               ruS_v,
  input  logic               ruS_b,
  output logic               err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [POS_W-1:0]    r_pos;
  logic [RUN_W-1:0]    r_zcnt;
  logic [RUN_W-1:0]    w_zcnt_nxt;
  logic [COEF_W-1:0]   r_stash;
  logic [COEF_W-1:0]   w_stash_nxt;
  logic                r_eos_pend;
  logic                w_eos_nxt;
  logic                r_err;
  logic                w_err_set;

  logic                w_ld;
  logic [COEF_W-1:0]   w_ld_d;
  logic                w_ld_e;
  logic                w_load_ok;

  logic [RUN_W-1:0]    w_run;
  logic [LEVEL_W-1:0]  w_lvl;
  logic                w_last;
  logic                w_overrun;

  assign w_run     = rlS_d[RUN_MSB:RUN_LSB];
  assign w_lvl     = rlS_d[LEVEL_MSB:LEVEL_LSB];
  assign w_last    = (r_pos == POS_W'(BLOCK_LEN - 1));
  // A token needs run+1 slots; it overruns when the last slot lies past the block end.
  assign w_overrun = ((POS_W+1)'(r_pos) + (POS_W+1)'(w_run)) > (POS_W+1)'(BLOCK_LEN - 1);

  assign rlS_b = reset | ~((r_state == ST_GET) & w_load_ok);

  always_comb begin
    w_state_nxt = r_state;
    w_zcnt_nxt  = r_zcnt;
    w_stash_nxt = r_stash;
    w_eos_nxt   = r_eos_pend;
    w_err_set   = 1'b0;
    w_ld        = 1'b0;
    w_ld_d      = '0;
    w_ld_e      = 1'b0;

    case (r_state)
      ST_GET: begin
        if (rlS_v && w_load_ok) begin
          if (rlS_e) begin
            if (r_pos == '0) begin
              w_state_nxt = ST_EOSOUT;
            end else begin
              w_err_set   = 1'b1;
              w_eos_nxt   = 1'b1;
              w_state_nxt = ST_FILL;
            end
          end else if (w_overrun) begin
            w_err_set   = 1'b1;
            w_ld        = 1'b1;
            w_state_nxt = w_last ? ST_GET : ST_FILL;
          end else if (w_run == '0) begin
            w_ld   = 1'b1;
            w_ld_d = sext_level(w_lvl);
            if ((rlS_d == EOB_CODE) && !w_last) begin
              w_state_nxt = ST_FILL;
            end
          end else begin
            w_ld        = 1'b1;
            w_zcnt_nxt  = w_run - RUN_W'(1);
            w_stash_nxt = (rlS_d == ZRL_CODE) ? '0 : sext_level(w_lvl);
            w_state_nxt = ST_ZEROS;
          end
        end
      end

      ST_ZEROS: begin
        if (w_load_ok) begin
          w_ld = 1'b1;
          if (r_zcnt != '0) begin
            w_zcnt_nxt = r_zcnt - RUN_W'(1);
          end else begin
            w_ld_d      = r_stash;
            w_state_nxt = ST_GET;
          end
        end
      end

      ST_FILL: begin
        if (w_load_ok) begin
          w_ld = 1'b1;
          if (w_last) begin
            w_state_nxt = r_eos_pend ? ST_EOSOUT : ST_GET;
          end
        end
      end

      ST_EOSOUT: begin
        if (w_load_ok) begin
          w_ld        = 1'b1;
          w_ld_e      = 1'b1;
          w_eos_nxt   = 1'b0;
          w_state_nxt = ST_GET;
        end
      end

      default: w_state_nxt = ST_GET;
    endcase
  end

  // EOS words do not occupy a block position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_GET;
      r_pos      <= '0;
      r_zcnt     <= '0;
      r_stash    <= '0;
      r_eos_pend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_zcnt     <= w_zcnt_nxt;
      r_stash    <= w_stash_nxt;
      r_eos_pend <= w_eos_nxt;
      if (w_ld && !w_ld_e) begin
        r_pos <= r_pos + POS_W'(1);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;

  jpeg_stream_reg #(
    .W (COEF_W)
  ) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .i_ld      (w_ld),
    .i_d       (w_ld_d),
    .i_e       (w_ld_e),
    .i_b       (ruS_b),
    .o_d       (ruS_d),
    .o_e       (ruS_e),
    .o_v       (ruS_v),
    .o_load_ok (w_load_ok)
  );

endmodule

// File: doc/jpeg_rle_expand.md
Name: jpeg_rle_expand

Overview:
Run-length expander directly upstream of the inverse-zigzag page. It converts the decoder's (run, level) token stream into exactly 64 sign-extended 16-bit coefficients per 8x8 block, in zigzag order. Its output drives the inverse-zigzag page's ruS input stream unchanged. It handles EOB/ZRL codes, back-pressure and end-of-stream, and flags malformed blocks.

Parameters:
BLOCK_LEN, 64, coefficients per block; the position counter is clog2(BLOCK_LEN) bits.
LEVEL_W, 12, width of the signed level field in a token.
COEF_W, 16, output coefficient width; level is sign-extended to this width.

Ports:
clock  in  1  single clock for the block.
reset  in  1  asynchronous, active-high reset.
rlS_d  in  16  token: [15:12] = run (0-15), [11:0] = level (two's complement).
rlS_e  in  1  end-of-stream marker; qualified by rlS_v.
rlS_v  in  1  token valid.
rlS_b  out  1  back-pressure to the producer; 1 = token not accepted this cycle.
ruS_d  out  16  coefficient to the inverse-zigzag page.
ruS_e  out  1  end-of-stream marker; qualified by ruS_v.
ruS_v  out  1  output valid.
ruS_b  in  1  back-pressure from the inverse-zigzag page.
err  out  1  sticky malformed-stream flag; cleared only by reset.

Behaviour:
- Transfer rule: a transfer happens on a rising clock edge where v=1 and b=0. Input data is ignored when rlS_v=0.
- Output register (ruS_d/e/v):
  - Loads a new value when it is empty (ruS_v=0) or draining (ruS_b=0).
  - Otherwise it holds d, e and v stable.
  - ruS_v drops to 0 when the register drains and nothing new is loaded.
- Reset, asynchronous, effective immediately:
  - ruS_d=0, ruS_e=0, ruS_v=0, rlS_b=1, err=0.
  - pos=0, state=GET. Mid-block contents are discarded.
- rlS_b=0 only when state=GET and the output register can load in that cycle. This is combinational from ruS_b and ruS_v.
- Latency: a token accepted at edge N puts its first coefficient on ruS at cycle N+1. Throughput is 1 coefficient per cycle when ruS_b=0.
- Token classes, after acceptance:
  - EOB (run=0, level=0): emit 0 and enter FILL. FILL emits zeros until pos wraps to 0. EOB at pos 0 produces 64 zeros.
  - ZRL (run=15, level=0): 16 zeros.
  - Other level=0 tokens: run+1 zeros.
  - run=0, level!=0: emit sext(level) immediately.
  - run>0, level!=0: emit 0 immediately, load zcnt=run-1, stash the level, enter ZEROS.
- FSM states:
  - GET: accepts tokens as above.
  - ZEROS: emit 0 while zcnt>0, decrementing zcnt. Then emit the stashed level (or 0 for ZRL/level-0 tokens) and return to GET.
  - FILL: emit 0 until end of block, then go to GET.
  - EOSOUT: emit one word with ruS_e=1, ruS_d=0, then go to GET.
- Position counter:
  - pos increments on every coefficient loaded into the output register; it does not increment on EOS words.
  - It wraps from 63 to 0; each wrap is a block boundary.
- Overrun: if a run would cross the block end, set err, emit zeros up to pos 63, drop the level, and return to GET at pos 0.
- End of stream: a token accepted with rlS_e=1 has its rlS_d ignored.
  - pos=0: go to EOSOUT.
  - pos!=0: set err, pad with zeros to the block end (FILL), then go to EOSOUT.
- Simultaneous events:
  - Load and drain in the same cycle are allowed; there is no bubble.
  - err set and an EOS output in the same cycle are both honoured.
- The held output must not change while ruS_v=1 and ruS_b=1.

Decomposition:
- Shared package jpeg_rle_pkg:
  - Token field slices: RUN_MSB/LSB, LEVEL_MSB/LSB.
  - EOB and ZRL code constants.
  - BLOCK_LEN.
  - FSM state encoding: GET, ZEROS, FILL, EOSOUT.
- One sub-module, jpeg_stream_reg: the d/e/v output register with its load/hold logic and a load_ok output. It is reusable by the other page-boundary stages.
- The FSM, run counter and position counter stay in jpeg_rle_expand.

Test Plan:
- Tokens {0x0005, 0x2FFF, 0x0000}, ruS_b=0:
  - Output 5, 0, 0, 0xFFFF, then 60 zeros; err=0.
  - First output appears 1 cycle after acceptance.
- 0xF000 x3, then 0x000A, then EOB:
  - Output 48 zeros, 0x000A at pos 48, then 15 zeros.
- Same stream with ruS_b toggled 1/0 every other cycle and held 1 for 5 cycles mid-ZEROS:
  - Identical 64-word sequence.
  - ruS_d is stable while back-pressured.
  - No token loss or duplication.
- Stream of 63 run=0 tokens of value 1, then 0x1003:
  - Overrun: output is 63 ones then one 0.
  - err=1; the next block starts at pos 0.
- rlS_e token at pos 0 -> single ruS_e=1 word, err=0. rlS_e at pos 10 -> 54 zeros, then the EOS word, err=1.
- Reset asserted mid-ZEROS:
  - ruS_v=0 and rlS_b=1 immediately.
  - After release, token 0x0007 produces 7 at pos 0.
